fir_dma: RTL and testbench
==========================

# fir_dma

Memory-to-stream / stream-to-memory mover that sits directly around the FIR engine. It fetches `len` input samples from a single-port word SRAM and drives them into the FIR's AXI-Stream slave (`ss_*`). It also accepts the FIR's AXI-Stream master output (`sm_*`) and writes each result back to SRAM. Firmware programs source, destination and length, pulses `start`, and waits for `done`.

## Interface
- `pADDR_WIDTH`, 12, SRAM byte-address width.
- `pDATA_WIDTH`, 32, sample, SRAM word and length width.
- `axis_clk`  in  1  single clock.
- `axis_rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; accepted only in IDLE.
- `src_base`  in  pADDR_WIDTH  byte address of the first input sample; word-aligned.
- `dst_base`  in  pADDR_WIDTH  byte address of the first result; word-aligned.
- `len`  in  pDATA_WIDTH  sample count.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at completion.
- `err`  out  1  sticky tlast-mismatch flag; cleared by an accepted `start`.
- `mem_EN`  out  1  SRAM enable.
- `mem_WE`  out  4  byte write enables; `4'hF` on writes, else 0.
- `mem_A`  out  pADDR_WIDTH  SRAM byte address.
- `mem_Di`  out  pDATA_WIDTH  write data.
- `mem_Do`  in  pDATA_WIDTH  read data, valid 1 cycle after the address.
- `ss_tvalid`, `ss_tdata`, `ss_tlast`  out  1/pDATA_WIDTH/1  stream to the FIR.
- `ss_tready`  in  1  FIR accepts the input sample.
- `sm_tvalid`, `sm_tdata`, `sm_tlast`  in  1/pDATA_WIDTH/1  stream from the FIR.
- `sm_tready`  out  1  accepts the FIR result.

## Operation
- **States**
  - IDLE → RUN when `start` is high. The block latches `src_base`, `dst_base` and `len`, zeroes the counters and clears `err`.
  - If the latched `len` is 0, the block goes IDLE → DONE instead.
  - RUN → DONE when `wr_cnt == len` and `sent_cnt == len`.
  - DONE → IDLE unconditionally after 1 cycle. `done` is high only in DONE.
- `start` in RUN or DONE is ignored.
- **Read engine**
  - Counter `rd_cnt` counts issued reads. Address = `src_base + 4*rd_cnt`, modulo 2^pADDR_WIDTH.
  - Issue condition: `rd_cnt < len`, AND FIFO occupancy plus reads in flight < 2, AND no write this cycle.
  - Read data lands in a 2-entry FIFO on the following cycle.
- **Stream out**
  - `ss_tvalid` = FIFO not empty. `ss_tdata` = FIFO head.
  - `ss_tlast` = (`sent_cnt == len-1`).
  - On `ss_tvalid && ss_tready`, the head is popped and `sent_cnt` increments.
  - `ss_tdata` is held stable while `ss_tvalid && !ss_tready`.
- **Write engine**
  - `sm_tready` = RUN && `wr_cnt < len`.
  - On `sm_tvalid && sm_tready`:
    - `mem_WE=4'hF`, `mem_A = dst_base + 4*wr_cnt` (mod 2^pADDR_WIDTH), `mem_Di = sm_tdata`.
    - `wr_cnt` increments.
  - Writes have port priority. A read wanting the same cycle stalls 1 cycle.
- **err**
  - Set on an accepted `sm_tlast` with `wr_cnt != len-1`.
  - Set on an accepted beat with `wr_cnt == len-1` and `sm_tlast` low.
  - Transfer still completes on the count.
- `mem_EN` is high on any read issue or write.
- Counters are pDATA_WIDTH wide. Address arithmetic is truncated to pADDR_WIDTH.

## Timing
- **Reset values:** state IDLE; `busy`=0, `done`=0, `err`=0; `mem_EN`=0, `mem_WE`=0, `mem_A`=0, `mem_Di`=0; `ss_tvalid`=0, `ss_tlast`=0, `ss_tdata`=0; `sm_tready`=0. FIFO is empty.
- Reset mid-RUN aborts the transfer immediately. No `done` is generated and the outputs take their reset values on the next edge.
- **Startup latency:** `start` in cycle 0 → `busy` in cycle 1 → first read issued in cycle 1 → `ss_tvalid` in cycle 2.
- **Sustained rate:** 1 sample/cycle on `ss_*` when `ss_tready` stays high and there are no write collisions.
- **FIFO boundaries:**
  - Full (2 entries): no reads are issued.
  - Simultaneous pop and incoming read data: occupancy is unchanged.
  - Read data never arrives to a full FIFO. The issue rule counts reads in flight, which guarantees this.
- `done` follows the last `ss` or `sm` handshake by exactly 1 cycle (RUN → DONE edge). `busy` falls in the same cycle that `done` rises.

## Test plan
- **Basic transfer.** Setup: len=4, src=0x000 holding {1,2,3,4}, dst=0x100, FIR model echoes each input ×2.
  - `ss` beats 1,2,3,4, with tlast on the 4th.
  - SRAM 0x100..0x10C = {2,4,6,8}.
  - `done` 1 cycle after the last write; `err`=0.
- **Input backpressure.** Setup: len=3, `ss_tready` low for 5 cycles after the first `ss_tvalid`.
  - `ss_tdata` holds sample 0 throughout.
  - Exactly 2 reads are issued before stalling.
  - All data arrives in order.
- **Write/read collision.** Setup: an `sm` beat is accepted in the same cycle a read wants the port.
  - The write occurs (`mem_WE=4'hF`).
  - The read is issued on the next cycle.
  - The `ss` sequence is unaffected.
- **Zero length.** Setup: len=0, then `start`.
  - `done` pulses in cycle 1.
  - No `mem_EN`, `ss_tvalid` or `sm_tready` activity at all.
- **tlast mismatch.** Setup: len=3, FIR asserts `sm_tlast` on beat 2.
  - `err`=1.
  - 3 writes still occur and `done` pulses.
  - `err` clears on the next `start`.
- **Reset mid-run and wrap.** Setup: len=8, assert `axis_rst` after 3 writes.
  - All outputs reach their reset values on the next edge, and no `done` pulses.
  - After reset, a new run with src=0xFF8, len=4 reads 0xFF8, 0xFFC, 0x000, 0x004.

Source files
------------

// File: rtl/fir_dma_if.sv
// fir_dma_if: bus bundle between the FIR DMA mover and its environment.
//   mem_*  single-port word SRAM (EN, byte WE, byte address, Di, Do)
//   ss_*   AXI-Stream towards the FIR engine input
//   sm_*   AXI-Stream from the FIR engine output
// Modports:
//   master  DMA side (drives SRAM controls, ss_* payload, sm_tready)
//   slave   environment side (SRAM read data, FIR stream signals)
interface fir_dma_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   mem_EN;
  logic [3:0]             mem_WE;
  logic [pADDR_WIDTH-1:0] mem_A;
  logic [pDATA_WIDTH-1:0] mem_Di;
  logic [pDATA_WIDTH-1:0] mem_Do;

  logic                   ss_tvalid;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tlast;
  logic                   ss_tready;

  logic                   sm_tvalid;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  logic                   sm_tready;

  modport master (
    output mem_EN, mem_WE, mem_A, mem_Di,
    input  mem_Do,
    output ss_tvalid, ss_tdata, ss_tlast,
    input  ss_tready,
    input  sm_tvalid, sm_tdata, sm_tlast,
    output sm_tready
  );

  modport slave (
    input  mem_EN, mem_WE, mem_A, mem_Di,
    output mem_Do,
    input  ss_tvalid, ss_tdata, ss_tlast,
    output ss_tready,
    output sm_tvalid, sm_tdata, sm_tlast,
    input  sm_tready
  );
endinterface

// File: rtl/fir_dma.sv
// fir_dma: memory-to-stream / stream-to-memory mover around the FIR engine.
// Fetches len samples from SRAM at src_base and streams them on ss_*,
// writes every sm_* result back to SRAM at dst_base.
// Ports:
//   axis_clk, axis_rst   clock, synchronous active-high reset
//   start                one-cycle pulse, accepted only while idle
//   src_base, dst_base   word-aligned byte addresses
//   len                  sample count
//   busy                 high while the transfer runs
//   done                 one-cycle completion pulse
//   err                  sticky tlast mismatch flag, cleared by a new start
//   bus                  fir_dma_if master: SRAM port and both streams
module fir_dma #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   start,
  input  logic [pADDR_WIDTH-1:0] src_base,
  input  logic [pADDR_WIDTH-1:0] dst_base,
  input  logic [pDATA_WIDTH-1:0] len,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  fir_dma_if.master              bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state_q;
  logic [pADDR_WIDTH-1:0] src_q, dst_q;
  logic [pDATA_WIDTH-1:0] len_q, rd_cnt_q, wr_cnt_q, sent_cnt_q;
  logic [pDATA_WIDTH-1:0] wr_cnt_d, sent_cnt_d, len_m1;
  logic                   err_q;
  logic                   rd_pend_q;
  logic [1:0]             fifo_cnt_q;
  logic [pDATA_WIDTH-1:0] fifo0_q, fifo1_q;

  logic                   run, wr_fire, rd_issue, ss_valid, pop;
  logic [1:0]             occ;
  logic [pADDR_WIDTH-1:0] rd_addr, wr_addr;

  assign len_m1  = len_q - pDATA_WIDTH'(1);
  assign rd_addr = src_q + {rd_cnt_q[pADDR_WIDTH-3:0], 2'b00};
  assign wr_addr = dst_q + {wr_cnt_q[pADDR_WIDTH-3:0], 2'b00};

  always_comb begin
    run           = (state_q == S_RUN);
    bus.sm_tready = run && (wr_cnt_q < len_q);
    wr_fire       = bus.sm_tvalid && bus.sm_tready;

    // The word returned by last cycle's read counts as FIFO content right
    // away (it sits on mem_Do), so the stream sees it one cycle after issue.
    ss_valid      = (fifo_cnt_q != 2'd0) || rd_pend_q;
    pop           = ss_valid && bus.ss_tready;
    occ           = fifo_cnt_q + {1'b0, rd_pend_q};
    rd_issue      = run && (rd_cnt_q < len_q) && (occ < 2'd2) && !wr_fire;

    bus.ss_tvalid = ss_valid;
    if (fifo_cnt_q != 2'd0) begin
      bus.ss_tdata = fifo0_q;
    end else if (rd_pend_q) begin
      bus.ss_tdata = bus.mem_Do;
    end else begin
      bus.ss_tdata = '0;
    end
    bus.ss_tlast  = ss_valid && (sent_cnt_q == len_m1);

    bus.mem_EN    = wr_fire || rd_issue;
    bus.mem_WE    = wr_fire ? 4'hF : 4'h0;
    if (wr_fire) begin
      bus.mem_A = wr_addr;
    end else if (rd_issue) begin
      bus.mem_A = rd_addr;
    end else begin
      bus.mem_A = '0;
    end
    bus.mem_Di    = wr_fire ? bus.sm_tdata : '0;

    wr_cnt_d      = wr_fire ? wr_cnt_q + pDATA_WIDTH'(1) : wr_cnt_q;
    sent_cnt_d    = pop ? sent_cnt_q + pDATA_WIDTH'(1) : sent_cnt_q;

    busy          = run;
    done          = (state_q == S_DONE);
    err           = err_q;
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      sent_cnt_q <= '0;
      err_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      fifo_cnt_q <= '0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
    end else begin
      rd_pend_q <= rd_issue;

      // Storage holds what is left of {fifo0, fifo1, mem_Do} after a pop.
      // The issue rule keeps occupancy plus in-flight reads at two or less.
      case ({rd_pend_q, pop})
        2'b10: begin
          if (fifo_cnt_q == 2'd0) begin
            fifo0_q <= bus.mem_Do;
          end else begin
            fifo1_q <= bus.mem_Do;
          end
          fifo_cnt_q <= fifo_cnt_q + 2'd1;
        end
        2'b01: begin
          fifo0_q    <= fifo1_q;
          fifo_cnt_q <= fifo_cnt_q - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd1) begin
            fifo0_q <= bus.mem_Do;
          end else if (fifo_cnt_q == 2'd2) begin
            fifo0_q <= fifo1_q;
            fifo1_q <= bus.mem_Do;
          end
        end
        default: ;
      endcase

      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_q      <= src_base;
            dst_q      <= dst_base;
            len_q      <= len;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            sent_cnt_q <= '0;
            err_q      <= 1'b0;
            state_q    <= (len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (rd_issue) begin
            rd_cnt_q <= rd_cnt_q + pDATA_WIDTH'(1);
          end
          wr_cnt_q   <= wr_cnt_d;
          sent_cnt_q <= sent_cnt_d;
          // tlast must appear on exactly the final result beat.
          if (wr_fire && (bus.sm_tlast != (wr_cnt_q == len_m1))) begin
            err_q <= 1'b1;
          end
          // Next-state counts so done lands one cycle after the last handshake.
          if ((wr_cnt_d == len_q) && (sent_cnt_d == len_q)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_dma.sv
`timescale 1ns/1ps
module tb_fir_dma;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [DW-1:0] len = '0;
  logic          busy, done, err;

  fir_dma_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

  fir_dma #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) dut (
    .axis_clk (clk),
    .axis_rst (rst),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    int            cyc;   // cycle relative to the start pulse, -1 = any
  } exp_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  exp_t  exp_rd[$];
  exp_t  exp_ss[$];
  exp_t  exp_wr[$];
  int    exp_done[$];
  beat_t fir_q[$];

  logic [DW-1:0] sram [0:1023];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int wr_seen = 0;
  int done_seen = 0;
  int act_cnt = 0;
  int hold_left = 0;
  bit hold_arm = 1'b0;
  bit force_en = 1'b0;
  int force_idx = 0;
  int beat_idx = 0;

  // environment-process scratch
  exp_t          m_e;
  int            m_d;
  bit            rd_pending = 1'b0;
  logic [DW-1:0] rd_word = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: DUT output appeared with nothing expected", name);
  endtask

  task automatic add_rd(input logic [AW-1:0] a, input int c);
    exp_rd.push_back('{addr: a, data: '0, last: 1'b0, cyc: c});
  endtask

  task automatic add_ss(input logic [DW-1:0] d, input logic l, input int c);
    exp_ss.push_back('{addr: '0, data: d, last: l, cyc: c});
  endtask

  task automatic add_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
    exp_wr.push_back('{addr: a, data: d, last: 1'b0, cyc: c});
  endtask

  // SRAM + FIR model (echoes x2) + monitors: drive on negedge, sample 1ns before posedge.
  initial begin
    bus.ss_tready = 1'b1;
    bus.sm_tvalid = 1'b0;
    bus.sm_tdata  = '0;
    bus.sm_tlast  = 1'b0;
    bus.mem_Do    = '0;
    forever begin
      @(negedge clk);
      if (hold_arm && bus.ss_tvalid) begin
        hold_arm  = 1'b0;
        hold_left = 5;
      end
      bus.ss_tready = (hold_left == 0);
      if (hold_left > 0) hold_left--;
      if (fir_q.size() > 0) begin
        bus.sm_tvalid = 1'b1;
        bus.sm_tdata  = fir_q[0].d;
        bus.sm_tlast  = fir_q[0].l;
      end else begin
        bus.sm_tvalid = 1'b0;
        bus.sm_tdata  = '0;
        bus.sm_tlast  = 1'b0;
      end
      #4;
      if (bus.mem_EN || bus.ss_tvalid || bus.sm_tready) act_cnt++;
      if (done) begin
        done_seen++;
        if (exp_done.size() > 0) begin
          m_d = exp_done.pop_front();
          if (m_d >= 0) check("done_cycle", DW'(cyc - start_cyc), DW'(m_d));
        end else unexpected("done");
      end
      rd_pending = 1'b0;
      if (bus.mem_EN && bus.mem_WE == 4'h0) begin
        rd_pending = 1'b1;
        rd_word    = sram[bus.mem_A[AW-1:2]];
        if (exp_rd.size() > 0) begin
          m_e = exp_rd.pop_front();
          check("rd_addr", DW'(bus.mem_A), DW'(m_e.addr));
          if (m_e.cyc >= 0) check("rd_cycle", DW'(cyc - start_cyc), DW'(m_e.cyc));
        end else unexpected("rd");
      end
      if (bus.mem_WE != 4'h0) begin
        check("wr_en", DW'(bus.mem_EN), DW'(1));
        check("wr_we", DW'(bus.mem_WE), DW'(4'hF));
        if (exp_wr.size() > 0) begin
          m_e = exp_wr.pop_front();
          check("wr_addr", DW'(bus.mem_A), DW'(m_e.addr));
          check("wr_data", bus.mem_Di, m_e.data);
          if (m_e.cyc >= 0) check("wr_cycle", DW'(cyc - start_cyc), DW'(m_e.cyc));
        end else unexpected("wr");
        sram[bus.mem_A[AW-1:2]] = bus.mem_Di;
        wr_seen++;
      end
      if (bus.ss_tvalid && !bus.ss_tready && exp_ss.size() > 0)
        check("ss_hold", bus.ss_tdata, exp_ss[0].data);
      if (bus.ss_tvalid && bus.ss_tready) begin
        if (exp_ss.size() > 0) begin
          m_e = exp_ss.pop_front();
          check("ss_data", bus.ss_tdata, m_e.data);
          check("ss_last", DW'(bus.ss_tlast), DW'(m_e.last));
          if (m_e.cyc >= 0) check("ss_cycle", DW'(cyc - start_cyc), DW'(m_e.cyc));
        end else unexpected("ss");
        fir_q.push_back('{d: bus.ss_tdata << 1,
                          l: force_en ? (beat_idx == force_idx) : bus.ss_tlast});
        beat_idx++;
      end
      if (bus.sm_tvalid && bus.sm_tready) void'(fir_q.pop_front());
      cyc++;
      @(posedge clk);
      #1;
      if (rd_pending) bus.mem_Do = rd_word;
    end
  end

  task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [DW-1:0] n);
    @(negedge clk);
    src_base  = s;
    dst_base  = d;
    len       = n;
    start     = 1'b1;
    start_cyc = cyc;
    beat_idx  = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n0;
    int k;
    n0 = done_seen;
    k  = 0;
    while (done_seen == n0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done_count"}, DW'(done_seen - n0), DW'(1));
  endtask

  task automatic drain_check(input string name);
    repeat (3) @(negedge clk);
    check({name, "_rd_left"},   DW'(exp_rd.size()),   DW'(0));
    check({name, "_ss_left"},   DW'(exp_ss.size()),   DW'(0));
    check({name, "_wr_left"},   DW'(exp_wr.size()),   DW'(0));
    check({name, "_done_left"}, DW'(exp_done.size()), DW'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},      DW'(busy),          DW'(0));
    check({name, "_done"},      DW'(done),          DW'(0));
    check({name, "_err"},       DW'(err),           DW'(0));
    check({name, "_mem_EN"},    DW'(bus.mem_EN),    DW'(0));
    check({name, "_mem_WE"},    DW'(bus.mem_WE),    DW'(0));
    check({name, "_mem_A"},     DW'(bus.mem_A),     DW'(0));
    check({name, "_mem_Di"},    bus.mem_Di,         DW'(0));
    check({name, "_ss_tvalid"}, DW'(bus.ss_tvalid), DW'(0));
    check({name, "_ss_tlast"},  DW'(bus.ss_tlast),  DW'(0));
    check({name, "_ss_tdata"},  bus.ss_tdata,       DW'(0));
    check({name, "_sm_tready"}, DW'(bus.sm_tready), DW'(0));
  endtask

  initial begin
    int w0;
    int d0;
    int a0;
    int k;
    for (int i = 0; i < 1024; i++) sram[i] = 32'hDEAD0000 | DW'(i);
    sram[0] = 1; sram[1] = 2; sram[2] = 3; sram[3] = 4;
    sram[12'h200 >> 2] = 32'h11; sram[(12'h200 >> 2) + 1] = 32'h22; sram[(12'h200 >> 2) + 2] = 32'h33;
    sram[12'h040 >> 2] = 5; sram[(12'h040 >> 2) + 1] = 6; sram[(12'h040 >> 2) + 2] = 7;
    for (int i = 0; i < 8; i++) sram[(12'h400 >> 2) + i] = 32'h100 + DW'(i);
    sram[12'hFF8 >> 2] = 32'hA0; sram[12'hFFC >> 2] = 32'hB0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic transfer: writes take the port at cycles 3,4,7,8 and push reads later
    add_rd(12'h000, 1); add_rd(12'h004, 2); add_rd(12'h008, 5); add_rd(12'h00C, 6);
    add_ss(1, 1'b0, 2); add_ss(2, 1'b0, 3); add_ss(3, 1'b0, 6); add_ss(4, 1'b1, 7);
    add_wr(12'h100, 2, 3); add_wr(12'h104, 4, 4); add_wr(12'h108, 6, 7); add_wr(12'h10C, 8, 8);
    exp_done.push_back(9);
    run(12'h000, 12'h100, 4);
    check("basic_busy_c1", DW'(busy), DW'(1));
    wait_done("basic", 40);
    drain_check("basic");
    check("basic_mem0", sram[12'h100 >> 2], 2);
    check("basic_mem1", sram[(12'h100 >> 2) + 1], 4);
    check("basic_mem2", sram[(12'h100 >> 2) + 2], 6);
    check("basic_mem3", sram[(12'h100 >> 2) + 3], 8);
    check("basic_err", DW'(err), DW'(0));

    // input backpressure: ss_tready low cycles 2..6, only two reads before the stall
    add_rd(12'h200, 1); add_rd(12'h204, 2); add_rd(12'h208, 10);
    add_ss(32'h11, 1'b0, 7); add_ss(32'h22, 1'b0, 8); add_ss(32'h33, 1'b1, 11);
    add_wr(12'h300, 32'h22, 8); add_wr(12'h304, 32'h44, 9); add_wr(12'h308, 32'h66, 12);
    exp_done.push_back(13);
    hold_arm = 1'b1;
    run(12'h200, 12'h300, 3);
    wait_done("bp", 60);
    drain_check("bp");
    check("bp_err", DW'(err), DW'(0));

    // tlast mismatch: FIR flags tlast on the second beat instead of the third
    add_rd(12'h040, -1); add_rd(12'h044, -1); add_rd(12'h048, -1);
    add_ss(5, 1'b0, -1); add_ss(6, 1'b0, -1); add_ss(7, 1'b1, -1);
    add_wr(12'h080, 10, -1); add_wr(12'h084, 12, -1); add_wr(12'h088, 14, -1);
    exp_done.push_back(-1);
    force_en  = 1'b1;
    force_idx = 1;
    run(12'h040, 12'h080, 3);
    wait_done("tlast", 60);
    drain_check("tlast");
    force_en = 1'b0;
    check("tlast_err_set", DW'(err), DW'(1));

    // zero length: done at cycle 1, no activity, err cleared by the accepted start
    a0 = act_cnt;
    exp_done.push_back(1);
    run(12'h000, 12'h000, 0);
    check("zero_err_cleared", DW'(err), DW'(0));
    wait_done("zero", 10);
    drain_check("zero");
    check("zero_activity", DW'(act_cnt - a0), DW'(0));

    // reset after 3 writes; a 4th write lands in the cycle reset is applied
    for (int i = 0; i < 4; i++) begin
      add_rd(AW'(12'h400 + 4 * i), -1);
      add_ss(32'h100 + DW'(i), 1'b0, -1);
      add_wr(AW'(12'h500 + 4 * i), (32'h100 + DW'(i)) << 1, -1);
    end
    w0 = wr_seen;
    d0 = done_seen;
    run(12'h400, 12'h500, 8);
    k = 0;
    while (wr_seen < w0 + 3 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("abort_three_writes", DW'(wr_seen - w0), DW'(3));
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_done", DW'(done_seen - d0), DW'(0));
    drain_check("abort");

    // address wrap from the top of the 4 KiB space
    add_rd(12'hFF8, -1); add_rd(12'hFFC, -1); add_rd(12'h000, -1); add_rd(12'h004, -1);
    add_ss(32'hA0, 1'b0, -1); add_ss(32'hB0, 1'b0, -1); add_ss(1, 1'b0, -1); add_ss(2, 1'b1, -1);
    add_wr(12'h010, 32'h140, -1); add_wr(12'h014, 32'h160, -1);
    add_wr(12'h018, 2, -1); add_wr(12'h01C, 4, -1);
    exp_done.push_back(-1);
    run(12'hFF8, 12'h010, 4);
    wait_done("wrap", 60);
    drain_check("wrap");
    check("wrap_err", DW'(err), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
